// File: rtl/lagarto_plic_target_controller.sv
// Claim/complete controller for one PLIC target context: pending and in-service tracking,
// threshold-gated priority arbitration and a two-state claim handshake.
module lagarto_plic_target_controller #(
  parameter int unsigned NUMBER_OF_INTERRUPT_SOURCES = 2,
  parameter int unsigned PRIORITY_WIDTH              = 3,
  parameter int unsigned INTERRUPT_ID_WIDTH          = 2
) (
  input  logic                                                  clk_i,
  input  logic                                                  rstn_i,
  input  logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_request_i,
  input  logic [NUMBER_OF_INTERRUPT_SOURCES*PRIORITY_WIDTH-1:0] source_priority_i,
  input  logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_enable_i,
  input  logic [PRIORITY_WIDTH-1:0]                             priority_threshold_i,
  input  logic                                                  claim_request_i,
  output logic                                                  claim_grant_o,
  output logic [INTERRUPT_ID_WIDTH-1:0]                         claim_id_o,
  input  logic                                                  complete_valid_i,
  input  logic [INTERRUPT_ID_WIDTH-1:0]                         complete_id_i,
  output logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_complete_o,
  output logic                                                  interrupt_notification_o,
  output logic [INTERRUPT_ID_WIDTH-1:0]                         interrupt_id_o
);

  localparam int unsigned N = NUMBER_OF_INTERRUPT_SOURCES;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                        state_q, state_d;
  logic [N-1:0]                  pending_q, pending_d;
  logic [N-1:0]                  in_service_q, in_service_d;
  logic [N-1:0]                  complete_q, complete_d;
  logic [INTERRUPT_ID_WIDTH-1:0] claim_id_q, claim_id_d;
  logic [INTERRUPT_ID_WIDTH-1:0] id_q, best_id;
  logic [PRIORITY_WIDTH-1:0]     best_prio, prio;

  // Seeding best_prio with the threshold folds the threshold test into the max search;
  // strict '>' keeps the lowest ID on ties.
  always_comb begin
    best_id   = '0;
    best_prio = priority_threshold_i;
    prio      = '0;
    for (int i = 0; i < N; i++) begin
      prio = source_priority_i[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
      if (pending_q[i] && interrupt_enable_i[i] && !in_service_q[i] && (prio > best_prio)) begin
        best_prio = prio;
        best_id   = INTERRUPT_ID_WIDTH'(i + 1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    claim_id_d   = claim_id_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    complete_d   = '0;

    // Completion acts on prior in-service state so a same-cycle claim can re-set the bit.
    if (complete_valid_i) begin
      for (int i = 0; i < N; i++) begin
        if ((complete_id_i == INTERRUPT_ID_WIDTH'(i + 1)) && in_service_q[i]) begin
          in_service_d[i] = 1'b0;
          complete_d[i]   = 1'b1;
        end
      end
    end

    case (state_q)
      StIdle: begin
        if (claim_request_i) begin
          claim_id_d = id_q;
          state_d    = StGrant;
          for (int i = 0; i < N; i++) begin
            if (id_q == INTERRUPT_ID_WIDTH'(i + 1)) begin
              pending_d[i]    = 1'b0;
              in_service_d[i] = 1'b1;
            end
          end
        end
      end
      StGrant: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    pending_d = pending_d | interrupt_request_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      in_service_q <= '0;
      complete_q   <= '0;
      claim_id_q   <= '0;
      id_q         <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      complete_q   <= complete_d;
      claim_id_q   <= claim_id_d;
      id_q         <= best_id;
    end
  end

  assign claim_grant_o            = (state_q == StGrant);
  assign claim_id_o               = claim_grant_o ? claim_id_q : '0;
  assign interrupt_complete_o     = complete_q;
  assign interrupt_id_o           = id_q;
  assign interrupt_notification_o = (id_q != '0);

endmodule

// File: tb/tb_lagarto_plic_target_controller.sv
// Scoreboard bench: stimulus pushes expected grants/completion pulses, a negedge monitor pops them.
module tb_lagarto_plic_target_controller;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] req;
  logic [5:0] prio;
  logic [1:0] en;
  logic [2:0] thr;
  logic       claim;
  logic       grant;
  logic [1:0] claim_id;
  logic       cvalid;
  logic [1:0] cid;
  logic [1:0] cpulse;
  logic       notif;
  logic [1:0] irq_id;

  int checks = 0;
  int passes = 0;
  logic [1:0] grant_q[$];
  logic [1:0] comp_q[$];

  lagarto_plic_target_controller #(
    .NUMBER_OF_INTERRUPT_SOURCES(2),
    .PRIORITY_WIDTH             (3),
    .INTERRUPT_ID_WIDTH         (2)
  ) dut (
    .clk_i                   (clk),
    .rstn_i                  (rstn),
    .interrupt_request_i     (req),
    .source_priority_i       (prio),
    .interrupt_enable_i      (en),
    .priority_threshold_i    (thr),
    .claim_request_i         (claim),
    .claim_grant_o           (grant),
    .claim_id_o              (claim_id),
    .complete_valid_i        (cvalid),
    .complete_id_i           (cid),
    .interrupt_complete_o    (cpulse),
    .interrupt_notification_o(notif),
    .interrupt_id_o          (irq_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic complete(input logic [1:0] id, input bit expect_pulse);
    cvalid = 1'b1;
    cid    = id;
    if (expect_pulse) comp_q.push_back(2'b01 << (id - 2'd1));
    tick();
    cvalid = 1'b0;
    cid    = 2'd0;
  endtask

  // Any grant or completion pulse without a queued expectation is a failure.
  always @(negedge clk) begin
    if (grant) begin
      if (grant_q.size() == 0) check("unexpected_grant", {30'd0, claim_id}, 32'hFFFF_FFFF);
      else check("claim_id", {30'd0, claim_id}, {30'd0, grant_q.pop_front()});
    end
    if (cpulse != 2'b00) begin
      if (comp_q.size() == 0) check("unexpected_complete", {30'd0, cpulse}, 32'hFFFF_FFFF);
      else check("complete_pulse", {30'd0, cpulse}, {30'd0, comp_q.pop_front()});
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_grant"}, {31'd0, grant}, 32'd0);
    check({name, "_claim_id"}, {30'd0, claim_id}, 32'd0);
    check({name, "_cpulse"}, {30'd0, cpulse}, 32'd0);
    check({name, "_notif"}, {31'd0, notif}, 32'd0);
    check({name, "_irq_id"}, {30'd0, irq_id}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; req = 2'b00; prio = {3'd3, 3'd3}; en = 2'b11; thr = 3'd0;
    claim = 1'b0; cvalid = 1'b0; cid = 2'd0;

    // Requests during reset must not survive.
    tick(2);
    req = 2'b11;
    tick();
    req = 2'b00;
    tick();
    rstn = 1'b1;
    tick();
    check_all_zero("reset");
    tick(2);
    check("reset_no_pending_notif", {31'd0, notif}, 32'd0);

    // Single source.
    prio = {3'd0, 3'd2}; thr = 3'd1;
    req = 2'b01;
    tick();
    req = 2'b00;
    check("single_t1_notif", {31'd0, notif}, 32'd0);
    tick();
    check("single_t2_notif", {31'd0, notif}, 32'd1);
    check("single_t2_id", {30'd0, irq_id}, 32'd1);
    claim = 1'b1;
    grant_q.push_back(2'd1);
    tick();
    claim = 1'b0;
    tick();
    check("single_t4_notif", {31'd0, notif}, 32'd0);
    complete(2'd1, 1'b1);
    tick();

    // Priority, plus claim held for three cycles: accept, ignored in GRANT, accept.
    prio = {3'd5, 3'd2}; thr = 3'd0;
    req = 2'b11;
    tick();
    req = 2'b00;
    tick();
    check("prio_id", {30'd0, irq_id}, 32'd2);
    claim = 1'b1;
    grant_q.push_back(2'd2);
    grant_q.push_back(2'd1);
    tick(3);
    claim = 1'b0;
    tick(2);
    check("prio_none_left_notif", {31'd0, notif}, 32'd0);
    complete(2'd2, 1'b1);
    complete(2'd2, 1'b0);
    complete(2'd0, 1'b0);
    complete(2'd3, 1'b0);
    complete(2'd1, 1'b1);
    tick(2);

    // Tie goes to ID 1; then complete ID 1 in the same cycle as claiming ID 2.
    prio = {3'd4, 3'd4};
    req = 2'b11;
    tick();
    req = 2'b00;
    tick();
    check("tie_id", {30'd0, irq_id}, 32'd1);
    claim = 1'b1;
    grant_q.push_back(2'd1);
    tick();
    claim = 1'b0;
    tick();
    check("tie_second_id", {30'd0, irq_id}, 32'd2);
    claim = 1'b1;
    grant_q.push_back(2'd2);
    complete(2'd1, 1'b1);
    claim = 1'b0;
    tick();
    complete(2'd2, 1'b1);
    tick(2);

    // Threshold equal to priority blocks notification; claim returns ID 0.
    prio = {3'd5, 3'd5}; thr = 3'd5;
    req = 2'b11;
    tick();
    req = 2'b00;
    tick(2);
    check("thr_notif", {31'd0, notif}, 32'd0);
    check("thr_id", {30'd0, irq_id}, 32'd0);
    claim = 1'b1;
    grant_q.push_back(2'd0);
    tick();
    claim = 1'b0;
    tick();

    // Lowering the threshold exposes still-pending sources.
    thr = 3'd0;
    tick();
    check("thr_lowered_id", {30'd0, irq_id}, 32'd1);

    // Reset asserted during GRANT: grant visible that cycle, gone after.
    claim = 1'b1;
    grant_q.push_back(2'd1);
    tick();
    claim = 1'b0;
    rstn = 1'b0;
    tick();
    check_all_zero("rst_in_grant");
    rstn = 1'b1;
    tick(2);
    check("rst_in_grant_notif", {31'd0, notif}, 32'd0);

    tick(2);
    check("grant_queue_drained", grant_q.size(), 32'd0);
    check("complete_queue_drained", comp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
